// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared sizes and FSM encoding for the PE instruction loader
package inst_loader_pkg;

  localparam int DEF_INST_WIDTH    = 64;
  localparam int DEF_IM_ADDR_WIDTH = 5;
  // PE valid-delay depth; the PE imem takes its delay line length from here too
  localparam int IM_DELAY          = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_SEND,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/inst_buf_ram.sv
// rtl/inst_buf_ram.sv - simple dual-port program buffer, one write port, one registered read port
module inst_buf_ram #(
  parameter int WIDTH = 64,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only moves on rd_en, so the last word sent stays on the bus
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - buffers a host program and broadcasts it to a PE imem as one gap-free burst
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int INST_WIDTH    = DEF_INST_WIDTH,
  parameter int IM_ADDR_WIDTH = DEF_IM_ADDR_WIDTH,
  parameter int COOLDOWN      = IM_DELAY + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_v,
  input  logic [INST_WIDTH-1:0]  host_data,
  output logic                   host_rdy,
  input  logic                   flush,
  input  logic                   start,
  output logic                   pe_clr,
  output logic                   inst_out_v,
  output logic [INST_WIDTH-1:0]  inst_out,
  output logic [IM_ADDR_WIDTH:0] count,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH  = 2**IM_ADDR_WIDTH;
  localparam int CW     = IM_ADDR_WIDTH + 1;
  localparam int WAIT_W = $clog2(COOLDOWN + DEPTH + 1);

  state_t                   state, state_nx;
  logic [CW-1:0]            count_q;
  logic [CW-1:0]            rd_ptr;
  logic [WAIT_W-1:0]        wait_cnt;
  logic                     done_q;
  logic                     wr_accept;
  logic                     send_last;
  logic                     wait_last;
  logic                     rd_en;
  logic [IM_ADDR_WIDTH-1:0] rd_addr;

  assign host_rdy  = (state == ST_IDLE) && (count_q < CW'(DEPTH)) && !start && !flush;
  assign wr_accept = host_v && host_rdy;
  assign send_last = (rd_ptr == count_q - CW'(1));
  // WAIT covers the PE delay line plus its replay of count words
  assign wait_last = (wait_cnt == WAIT_W'(COOLDOWN) + WAIT_W'(count_q) - WAIT_W'(1));

  inst_buf_ram #(
    .WIDTH (INST_WIDTH),
    .AW    (IM_ADDR_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (count_q[IM_ADDR_WIDTH-1:0]),
    .wr_data (host_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (inst_out)
  );

  // CLR prefetches word 0; each non-final SEND cycle fetches the next word
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    rd_addr  = '0;
    case (state)
      ST_IDLE: begin
        if (!flush && start && (count_q != '0)) state_nx = ST_CLR;
      end
      ST_CLR: begin
        state_nx = ST_SEND;
        rd_en    = 1'b1;
      end
      ST_SEND: begin
        if (send_last) begin
          state_nx = ST_WAIT;
        end else begin
          rd_en   = 1'b1;
          rd_addr = rd_ptr[IM_ADDR_WIDTH-1:0] + IM_ADDR_WIDTH'(1);
        end
      end
      ST_WAIT: begin
        if (wait_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count_q  <= '0;
      rd_ptr   <= '0;
      wait_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == ST_WAIT) && wait_last;
      if (state == ST_IDLE) begin
        if (flush)          count_q <= '0;
        else if (wr_accept) count_q <= count_q + CW'(1);
      end
      if (state == ST_CLR)       rd_ptr <= '0;
      else if (state == ST_SEND) rd_ptr <= rd_ptr + CW'(1);
      if (state == ST_SEND)      wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign pe_clr     = (state == ST_CLR);
  assign inst_out_v = (state == ST_SEND);
  assign busy       = (state != ST_IDLE);
  assign done       = done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed bench for inst_loader with a behavioural PE imem on its output
module tb_inst_loader;

  localparam int IW     = 64;
  localparam int AW     = 5;
  localparam int DEPTH  = 32;
  localparam int COOL   = 18;
  localparam int PE_LAT = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_v = 1'b0;
  logic [IW-1:0] host_data = '0;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic          host_rdy, pe_clr, inst_out_v, busy, done;
  logic [IW-1:0] inst_out;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_w [DEPTH];

  always #5 clk = ~clk;

  inst_loader #(
    .INST_WIDTH    (IW),
    .IM_ADDR_WIDTH (AW),
    .COOLDOWN      (COOL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_v     (host_v),
    .host_data  (host_data),
    .host_rdy   (host_rdy),
    .flush      (flush),
    .start      (start),
    .pe_clr     (pe_clr),
    .inst_out_v (inst_out_v),
    .inst_out   (inst_out),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  // PE imem: stores words on valid, replays them after its valid-delay line
  logic [IW-1:0]     pe_mem [DEPTH];
  int                pe_wp, pe_rp;
  logic [PE_LAT-1:0] pe_dl;
  logic              pe_rep_v;
  logic [IW-1:0]     pe_rep_d;
  assign pe_rep_v = pe_dl[PE_LAT-1];
  assign pe_rep_d = pe_mem[pe_rp % DEPTH];

  always @(posedge clk) begin
    if (rst || pe_clr) begin
      pe_wp <= 0;
      pe_rp <= 0;
      pe_dl <= '0;
    end else begin
      pe_dl <= {pe_dl[PE_LAT-2:0], inst_out_v};
      if (inst_out_v) begin
        pe_mem[pe_wp % DEPTH] <= inst_out;
        pe_wp <= pe_wp + 1;
      end
      if (pe_rep_v) pe_rp <= pe_rp + 1;
    end
  end

  int rep_cnt = 0;
  bit rep_bad = 1'b0;
  always @(negedge clk) begin
    if (pe_rep_v) begin
      if (rep_cnt >= DEPTH || pe_rep_d !== exp_w[rep_cnt]) rep_bad = 1'b1;
      rep_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic write_word(input logic [IW-1:0] d, output logic acc);
    host_v    = 1'b1;
    host_data = d;
    @(negedge clk);
    acc = host_rdy;
    @(posedge clk); #1;
    host_v = 1'b0;
  endtask

  task automatic load(input int n, input logic [IW-1:0] base);
    logic acc;
    for (int i = 0; i < n; i++) begin
      write_word(base + 64'(i), acc);
      exp_w[i] = base + 64'(i);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    bit q = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (pe_clr || inst_out_v || done || busy) q = 1'b0;
    end
    chk(tag, 64'(q), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic broadcast(input string tag, input int n, input bit poke);
    int wc = 0;
    bit clean = 1'b1;
    rep_cnt = 0;
    rep_bad = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      host_v    = 1'b1;
      host_data = '1;
      flush     = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_pe_clr"}, 64'(pe_clr), 64'd1);
    chk({tag, "_clr_v"}, 64'(inst_out_v), 64'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s_v%0d", tag, k), 64'(inst_out_v), 64'd1);
      chk($sformatf("%s_d%0d", tag, k), inst_out, exp_w[k]);
    end
    host_v = 1'b0;
    flush  = 1'b0;
    while (!done && wc < 200) begin
      @(negedge clk);
      wc++;
      if (inst_out_v || pe_clr) clean = 1'b0;
    end
    chk({tag, "_done_lat"}, 64'(wc), 64'(COOL + n + 1));
    chk({tag, "_quiet"}, 64'(clean), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_rep_n"}, 64'(rep_cnt), 64'(n));
    chk({tag, "_rep_ok"}, 64'(rep_bad), 64'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    int acc_n;
    logic acc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_v", 64'(inst_out_v), 64'd0);
    chk("rst_clr", 64'(pe_clr), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", inst_out, 64'd0);
    chk("rst_rdy", 64'(host_rdy), 64'd1);
    @(posedge clk); #1;

    start = 1'b1;
    @(negedge clk);
    chk("start_masks_rdy", 64'(host_rdy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    quiet("empty_start", 30);

    load(5, 64'hA0);
    @(negedge clk);
    chk("ld_count", 64'(count), 64'd5);
    @(posedge clk); #1;
    broadcast("ld", 5, 1'b0);

    broadcast("rs", 5, 1'b1);
    @(negedge clk);
    chk("rs_count", 64'(count), 64'd5);
    @(posedge clk); #1;

    flush = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("fs_count", 64'(count), 64'd0);
    @(posedge clk); #1;
    quiet("fs_quiet", 30);

    acc_n = 0;
    for (int i = 0; i < 40; i++) begin
      write_word(64'h100 + 64'(i), acc);
      if (acc) acc_n++;
      if (i < DEPTH) exp_w[i] = 64'h100 + 64'(i);
    end
    chk("full_accepted", 64'(acc_n), 64'd32);
    @(negedge clk);
    chk("full_count", 64'(count), 64'd32);
    chk("full_rdy", 64'(host_rdy), 64'd0);
    @(posedge clk); #1;
    broadcast("full", 32, 1'b0);

    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    load(8, 64'hC0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("mid_word3", inst_out, 64'hC3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_v", 64'(inst_out_v), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_clr", 64'(pe_clr), 64'd0);
    @(posedge clk); #1;
    quiet("mid_rst_quiet", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
